vga_frame_regbank: RTL

- Double-buffered 16x8 display register bank that feeds the VGA controller's data input.
- Serves the VGA pointer stage: it receives the 4-bit memory address and returns the 8-bit display data byte, both on its display read port.
- Writer side (RTC/keyboard control logic) updates a shadow bank through a request/acknowledge handshake. A commit request publishes the shadow at the next vertical-sync edge, so a frame never shows a half-updated value set.

---
 rtl/vga_frame_regbank.sv | 126 ++++++++++++
 1 files changed

// File: rtl/vga_frame_regbank.sv
// Double-buffered display register bank: the VGA pointer stage reads the active bank while
// the writer fills the shadow, which is published at the next VSync edge and then resynchronised.
module vga_frame_regbank #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              WrReq,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [DATA_W-1:0] WrData,
    output logic              WrAck,
    input  logic              Commit,
    input  logic              VSync,
    input  logic [ADDR_W-1:0] MemAddrIN,
    output logic [DATA_W-1:0] MemDataOut,
    output logic              SwapPending,
    output logic              Busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        COPY    = 2'd2
    } state_t;

    state_t            state_reg;
    logic [DATA_W-1:0] bank_reg [2][DEPTH];
    logic              active_sel_reg;
    logic              vs_q_reg;
    logic              commit_latch_reg;
    logic              wr_ack_reg;
    logic              swap_pending_reg;
    logic              busy_reg;
    logic [ADDR_W-1:0] cnt_reg;
    logic [DATA_W-1:0] mem_data_reg;

    logic vs_edge;
    logic swap;
    logic wr_accept;
    logic shadow_sel;

    assign shadow_sel = ~active_sel_reg;
    assign vs_edge    = (VSync == VSYNC_POL) && (vs_q_reg != VSYNC_POL);
    assign swap       = (state_reg == PENDING) && vs_edge;
    // The ack cycle itself blocks acceptance, so a held request cannot be stored twice.
    assign wr_accept  = WrReq && !wr_ack_reg && (state_reg != COPY) && !swap;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    bank_reg[b][i] <= '0;
                end
            end
            state_reg        <= IDLE;
            active_sel_reg   <= 1'b0;
            vs_q_reg         <= ~VSYNC_POL;
            commit_latch_reg <= 1'b0;
            wr_ack_reg       <= 1'b0;
            swap_pending_reg <= 1'b0;
            busy_reg         <= 1'b0;
            cnt_reg          <= '0;
            mem_data_reg     <= '0;
        end else begin
            vs_q_reg     <= VSync;
            // Uses the pre-swap selector, so the swap cycle still returns old-bank data.
            mem_data_reg <= bank_reg[active_sel_reg][MemAddrIN];
            wr_ack_reg   <= wr_accept;

            if (wr_accept) begin
                bank_reg[shadow_sel][WrAddr] <= WrData;
            end

            case (state_reg)
                IDLE: begin
                    if (Commit) begin
                        state_reg        <= PENDING;
                        swap_pending_reg <= 1'b1;
                    end
                end
                PENDING: begin
                    if (vs_edge) begin
                        active_sel_reg   <= ~active_sel_reg;
                        swap_pending_reg <= 1'b0;
                        busy_reg         <= 1'b1;
                        commit_latch_reg <= 1'b0;
                        cnt_reg          <= '0;
                        state_reg        <= COPY;
                    end
                end
                COPY: begin
                    // Selector already points at the newly published bank.
                    bank_reg[shadow_sel][cnt_reg] <= bank_reg[active_sel_reg][cnt_reg];
                    cnt_reg <= cnt_reg + ADDR_W'(1);
                    if (Commit) begin
                        commit_latch_reg <= 1'b1;
                    end
                    if (cnt_reg == ADDR_W'(DEPTH - 1)) begin
                        busy_reg         <= 1'b0;
                        commit_latch_reg <= 1'b0;
                        cnt_reg          <= '0;
                        if (commit_latch_reg || Commit) begin
                            state_reg        <= PENDING;
                            swap_pending_reg <= 1'b1;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign WrAck       = wr_ack_reg;
    assign MemDataOut  = mem_data_reg;
    assign SwapPending = swap_pending_reg;
    assign Busy        = busy_reg;

endmodule
